// File: rtl/multi_mode_shift_register.sv
// Multi-cycle shift/rotate register: parallel load, then a start that runs a
// programmable number of 1-bit LSL/LSR/ASR/ROL steps with a busy/done handshake.
module multi_mode_shift_register #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic             serial_in,
    output logic [WIDTH-1:0] out,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;

    state_t           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       step_mode;
    logic [WIDTH:0]   step_res;
    logic [WIDTH-1:0] out_d;
    logic             carry_d;
    logic             done_d;

    // The first step happens on the start edge, before mode has been latched.
    assign step_mode = (state_q == IDLE) ? mode : mode_q;

    // One step of the selected operation, packed as {carry, value}.
    always_comb begin
        step_res = {carry_out, out};
        case (step_mode)
            MODE_LSL: step_res = {out, serial_in};
            MODE_LSR: step_res = {out[0], serial_in, out[WIDTH-1:1]};
            MODE_ASR: step_res = {out[0], out[WIDTH-1], out[WIDTH-1:1]};
            default:  step_res = {out[WIDTH-1], out[WIDTH-2:0], out[WIDTH-1]};
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        out_d   = out;
        carry_d = carry_out;
        done_d  = 1'b0;
        if (load) begin
            out_d   = in;
            carry_d = 1'b0;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                mode_d = mode;
                if (amount == '0) begin
                    carry_d = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    {carry_d, out_d} = step_res;
                    cnt_d = amount - AMT_W'(1);
                    if (amount == AMT_W'(1)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
        end else begin
            {carry_d, out_d} = step_res;
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out       <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
        end else begin
            out       <= out_d;
            carry_out <= carry_d;
            done      <= done_d;
        end
    end

    // busy is a pure decode of the state flop, so it carries no input path.
    always_comb begin
        busy = (state_q == SHIFT);
    end

endmodule

// File: tb/tb_multi_mode_shift_register.sv
// Bench for multi_mode_shift_register: directed scenarios plus random traffic,
// every edge compared against a remaining-steps reference model.
module tb_multi_mode_shift_register;

    localparam int W = 8;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] din;
    logic         start;
    logic [1:0]   mode;
    logic [A-1:0] amount;
    logic         serial_in;
    logic [W-1:0] out;
    logic         carry_out;
    logic         busy;
    logic         done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: value, carry, steps still owed, latched mode.
    logic [W-1:0] m_out;
    logic         m_carry;
    logic         m_done;
    int           m_rem;
    logic [1:0]   m_mode;

    multi_mode_shift_register #(.WIDTH(W), .AMT_W(A)) dut (
        .clk(clk), .rst(rst), .load(load), .in(din), .start(start),
        .mode(mode), .amount(amount), .serial_in(serial_in),
        .out(out), .carry_out(carry_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_out = '0; m_carry = 1'b0; m_done = 1'b0; m_rem = 0; m_mode = 2'b00;
    endtask

    task automatic model_step(input logic [1:0] md);
        int v;
        v = int'(m_out);
        case (md)
            2'd0: begin m_carry = v[W-1]; v = ((v * 2) + int'(serial_in)) % 256; end
            2'd1: begin m_carry = v[0];   v = (v / 2) + (int'(serial_in) * 128); end
            2'd2: begin m_carry = v[0];   v = (v / 2) + (v >= 128 ? 128 : 0); end
            default: begin m_carry = v[W-1]; v = ((v * 2) % 256) + (v / 128); end
        endcase
        m_out = v[W-1:0];
    endtask

    // Applied at every rising edge using the inputs stable across that edge.
    task automatic model_edge();
        m_done = 1'b0;
        if (rst) begin
            model_reset();
        end else if (load) begin
            m_out = din; m_carry = 1'b0; m_rem = 0;
        end else if (m_rem == 0 && start) begin
            if (amount == 0) begin
                m_carry = 1'b0; m_done = 1'b1;
            end else begin
                m_mode = mode;
                model_step(mode);
                m_rem = int'(amount) - 1;
                if (m_rem == 0) m_done = 1'b1;
            end
        end else if (m_rem > 0) begin
            model_step(m_mode);
            m_rem--;
            if (m_rem == 0) m_done = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("out", 32'(out), 32'(m_out));
        chk("carry_out", 32'(carry_out), 32'(m_carry));
        chk("busy", 32'(busy), 32'(m_rem != 0));
        chk("done", 32'(done), 32'(m_done));
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; din = v;
        tick();
        load = 1'b0;
    endtask

    // Starts one operation and watches a bounded window for busy/done.
    task automatic run_op(input logic [1:0] md, input int amt, input logic sin,
                          output int busy_n, output int done_n,
                          output logic [W-1:0] fin_out, output logic fin_carry);
        busy_n = 0; done_n = 0; fin_out = 'x; fin_carry = 1'bx;
        start = 1'b1; mode = md; amount = A'(amt); serial_in = sin;
        for (int i = 0; i < amt + 3; i++) begin
            tick();
            start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                done_n++; fin_out = out; fin_carry = carry_out;
            end
        end
    endtask

    initial begin
        int bn, dn;
        logic [W-1:0] fo;
        logic fc;

        rst = 1'b1; load = 1'b0; din = '0; start = 1'b0; mode = 2'b00;
        amount = '0; serial_in = 1'b0;
        model_reset();
        #1;
        chk("reset_out", 32'(out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        tick();
        rst = 1'b0;

        // LSL by 3
        do_load(8'hB5);
        run_op(2'b00, 3, 1'b0, bn, dn, fo, fc);
        chk("lsl3_out", 32'(fo), 32'hA8);
        chk("lsl3_carry", 32'(fc), 32'h1);
        chk("lsl3_busy_cycles", 32'(bn), 32'd2);
        chk("lsl3_done_cycles", 32'(dn), 32'd1);

        // ASR by 2
        do_load(8'h96);
        run_op(2'b10, 2, 1'b0, bn, dn, fo, fc);
        chk("asr2_out", 32'(fo), 32'hE5);
        chk("asr2_carry", 32'(fc), 32'h1);
        chk("asr2_busy_cycles", 32'(bn), 32'd1);
        chk("asr2_done_cycles", 32'(dn), 32'd1);

        // LSR by 4 with serial fill of ones
        do_load(8'h0F);
        run_op(2'b01, 4, 1'b1, bn, dn, fo, fc);
        chk("lsr4_out", 32'(fo), 32'hF0);
        chk("lsr4_carry", 32'(fc), 32'h1);

        // ROL by a full width returns the original value
        do_load(8'h5A);
        run_op(2'b11, 8, 1'b0, bn, dn, fo, fc);
        chk("rol8_out", 32'(fo), 32'h5A);
        chk("rol8_carry", 32'(fc), 32'h0);

        // Zero amount: done only
        do_load(8'h3C);
        run_op(2'b00, 0, 1'b1, bn, dn, fo, fc);
        chk("amt0_out", 32'(fo), 32'h3C);
        chk("amt0_carry", 32'(fc), 32'h0);
        chk("amt0_busy_cycles", 32'(bn), 32'd0);
        chk("amt0_done_cycles", 32'(dn), 32'd1);

        // LSL by 5 with a start pulsed mid-operation that must be ignored
        start = 1'b1; mode = 2'b00; amount = A'(5); serial_in = 1'b0;
        tick();
        start = 1'b0; mode = 2'b11;
        tick();
        start = 1'b1; amount = A'(2);
        tick();
        start = 1'b0;
        dn = 0; fo = 'x; fc = 1'bx;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) begin dn++; fo = out; fc = carry_out; end
        end
        chk("lsl5_out", 32'(fo), 32'h80);
        chk("lsl5_carry", 32'(fc), 32'h1);
        chk("lsl5_done_cycles", 32'(dn), 32'd1);

        // Load aborts a ROL in progress
        do_load(8'h81);
        start = 1'b1; mode = 2'b11; amount = A'(6);
        tick();
        start = 1'b0;
        tick();
        load = 1'b1; din = 8'h22;
        tick();
        load = 1'b0;
        chk("abort_out", 32'(out), 32'h22);
        chk("abort_carry", 32'(carry_out), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        dn = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);

        // Asynchronous reset mid-operation
        do_load(8'hFF);
        start = 1'b1; mode = 2'b00; amount = A'(5); serial_in = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out", 32'(out), 32'h0);
        chk("async_rst_carry", 32'(carry_out), 32'h0);
        chk("async_rst_busy", 32'(busy), 32'h0);
        chk("async_rst_done", 32'(done), 32'h0);
        model_reset();
        tick();
        rst = 1'b0;
        do_load(8'h01);
        run_op(2'b00, 1, 1'b0, bn, dn, fo, fc);
        chk("post_rst_out", 32'(fo), 32'h02);
        chk("post_rst_carry", 32'(fc), 32'h0);
        chk("post_rst_done_cycles", 32'(dn), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            load      = ($urandom_range(0, 11) == 0);
            din       = W'($urandom);
            start     = ($urandom_range(0, 2) == 0);
            mode      = 2'($urandom_range(0, 3));
            amount    = A'($urandom_range(0, 15));
            serial_in = 1'($urandom);
            tick();
        end
        load = 1'b0; start = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi_mode_shift_register.md
Name: multi_mode_shift_register

Overview:
Parametrised, multi-cycle shift/rotate register for the multiplier and divider datapaths. Supersedes the single-step left shifter. Supports a parallel load, then a start command that runs a programmable number of 1-bit shift steps in one of four modes, with serial fill and carry-out. A busy/done handshake lets the controller FSM wait for completion instead of counting cycles itself.

Parameters:
WIDTH, 8, register width in bits; must be 2 or more.
AMT_W, 4, width of the shift-amount field; maximum amount is 2^AMT_W-1.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-high reset.
load  input  1  parallel load strobe.
in  input  WIDTH  parallel load data.
start  input  1  begin a shift operation.
mode  input  2  operation: 00 LSL, 01 LSR, 10 ASR, 11 ROL.
amount  input  AMT_W  number of 1-bit steps.
serial_in  input  1  fill bit for LSL (enters at LSB) and LSR (enters at MSB).
out  output  WIDTH  register contents (registered).
carry_out  output  1  last bit shifted or rotated out (registered).
busy  output  1  high while the remaining steps are in progress (registered).
done  output  1  one-cycle completion pulse (registered).

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - out=0, carry_out=0, busy=0, done=0, state=IDLE, step counter=0.
- States:
  - IDLE: the only state in which start is accepted.
  - SHIFT: steps remain.
- Priority at each edge: rst, then load, then start (IDLE only), then the SHIFT step.
- done defaults to 0 on every edge unless set by a rule below.
- load, in any state:
  - out<=in, carry_out<=0, state<=IDLE, busy<=0, done<=0.
  - Aborts an operation in progress; no done pulse is produced.
- start in IDLE with amount=k, k>0:
  - mode is latched; later changes to mode are ignored.
  - The first step executes on the same edge (E0). Counter<=k-1.
  - If k>1: state<=SHIFT, busy<=1.
  - If k=1: state stays IDLE, done<=1.
- SHIFT state, each edge:
  - Execute one step and decrement the counter.
  - When the step just executed is the last one (counter was 1): state<=IDLE, busy<=0, done<=1.
- Timing for amount k:
  - Steps occur on edges E0..E(k-1).
  - busy is high after E0 through E(k-2), i.e. k-1 cycles.
  - done is high for exactly one cycle after E(k-1).
  - The final out/carry_out are valid in the same cycle done is high.
- start with amount=0 in IDLE:
  - out unchanged, carry_out<=0, done<=1 after E0, busy stays 0.
- start while in SHIFT is ignored.
- A start on the same edge as the done-producing edge is ignored; start is accepted from the cycle in which done is high.
- Step definitions:
  - LSL: {carry_out,out} <= {out, serial_in}.
  - LSR: {out,carry_out} <= {serial_in, out}.
  - ASR: {out,carry_out} <= {out[WIDTH-1], out}.
  - ROL: out <= {out[WIDTH-2:0], out[WIDTH-1]}, carry_out <= out[WIDTH-1].
- serial_in is sampled live on every step edge, so a caller can stream bits in.
- amount may be WIDTH or more:
  - LSL/LSR continue filling with serial_in.
  - ASR saturates to all-sign.
  - ROL wraps modulo WIDTH.
  - carry_out is always the last bit out.
- Backward compatibility: mode=00, serial_in=0, amount=1 reproduces the old single-step left shift. out and carry_out are identical, with done in place of an external cycle count.
- No combinational path from inputs to outputs.

Test Plan:
1. WIDTH=8, load 0xB5; start LSL, amount=3, serial_in=0 -> busy high 2 cycles; done pulses 1 cycle after the 3rd edge; out=0xA8, carry_out=1.
2. load 0x96; start ASR, amount=2 -> out=0xE5, carry_out=1; busy high 1 cycle; done high 1 cycle.
3. load 0x0F; start LSR, amount=4, serial_in held 1 -> out=0xF0, carry_out=1. Separately, load 0x5A; ROL, amount=8 -> out=0x5A, carry_out=0.
4. load 0x3C; start with amount=0 -> done next cycle, busy never high, out=0x3C, carry_out=0. Also cover start pulsed while busy (LSL, amount=5): ignored, and exactly 5 steps occur.
5. load 0x81; start ROL, amount=6; assert load with in=0x22 after the 2nd step -> out=0x22, carry_out=0, busy=0, no done pulse ever for the aborted operation.
6. Assert rst asynchronously mid-operation (LSL, amount=5, after step 2) -> out=0, carry_out=0, busy=0, done=0 immediately. After rst release, load 0x01 and LSL amount=1 -> out=0x02, done pulses.
